// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped console transmitter.
// Snoops the MEM-stage store bus, queues byte stores to TX_ADDR in a small
// FIFO and serialises them as UART frames on tx (8N1 by default). A status
// word {overflow, tx_busy, fifo_full} is readable at STATUS_ADDR.
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit between the
// last data bit and the stop bit, giving 8E1 frames).
// FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.

module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [7:0]  TX_ADDR      = 8'hFF,
    parameter logic [7:0]  STATUS_ADDR  = 8'hFE
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic                          wren,
    input  logic [7:0]                    addr,
    input  logic [31:0]                   din,
    output logic [31:0]                   rdata,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    // Frame states; PARITY only exists when the parity bit is enabled.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } txState_e;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]        fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;

    logic              storeHit;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              push;
    logic              pop;
    logic [7:0]        headByte;

    // ------------------------------------------------------------------
    // Serialiser state
    // ------------------------------------------------------------------
    txState_e          state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bitIdx_q, bitIdx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              baudDone;
    logic              busy;
`ifdef UART_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // Only the low byte of the store data is used by this peripheral.
    logic              unusedDinBits;
    assign unusedDinBits = ^din[31:8];

    // Store decode and FIFO status; full is taken from the registered count,
    // so a push is judged before any pop happening on the same edge.
    always_comb begin
        storeHit  = wren && (addr == TX_ADDR);
        fifoFull  = (count_q == DEPTH_CNT);
        fifoEmpty = (count_q == '0);
        push      = storeHit && !fifoFull;
        pop       = (state_q == IDLE) && !fifoEmpty;
        headByte  = fifoMem[rdPtr_q];
    end

    // Next values for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (storeHit && fifoFull) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO data array; contents need no reset because count guards reads.
    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wrPtr_q] <= din[7:0];
        end
    end

    // FIFO pointer, occupancy and overflow registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------

    // State register: state, baud counter, shifter and the registered tx pin.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bitIdx_q <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bitIdx_q <= bitIdx_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
`ifdef UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic: each bit slot lasts CLKS_PER_BIT cycles.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bitIdx_d = bitIdx_q;
        shreg_d  = shreg_q;
`ifdef UART_PARITY_EN
        parity_d = parity_q;
`endif
        baudDone = (baud_q == BAUD_LAST);

        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (pop) begin
                    shreg_d  = headByte;
                    bitIdx_d = '0;
                    state_d  = START;
`ifdef UART_PARITY_EN
                    parity_d = ^headByte;
`endif
                end
            end
            START: begin
                if (baudDone) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baudDone) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (baudDone) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                if (baudDone) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Output logic: tx is precomputed from the next state so the pin changes
    // on the same edge as the state; busy reflects the current state.
    always_comb begin
        tx_d = 1'b1;
        busy = (state_q != IDLE);
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // Status word read port; purely combinational, no side effects.
    always_comb begin
        rdata = '0;
        if (addr == STATUS_ADDR) begin
            rdata = {29'b0, overflow_q, busy, fifoFull};
        end
    end

    assign tx         = tx_q;
    assign tx_busy    = busy;
    assign fifo_full  = fifoFull;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx.
// Whole frames are captured one tx sample per cycle and compared against a
// waveform built from the byte value. Honours UART_PARITY_EN.

module tb_mmio_uart_tx;

    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic        clock = 1'b0;
    logic        clear;
    logic        wren;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_busy;
    logic        fifo_full;
    logic [3:0]  fifo_count;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8),
        .TX_ADDR      (8'hFF),
        .STATUS_ADDR  (8'hFE)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .wren       (wren),
        .addr       (addr),
        .din        (din),
        .rdata      (rdata),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    // 10 ns clock
    always #5 clock = ~clock;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    // Drive one bus cycle starting at a negedge; returns at the next negedge.
    task automatic applyStimulus(input logic wr, input logic [7:0] a, input logic [31:0] d);
        wren = wr;
        addr = a;
        din  = d;
        @(posedge clock);
        @(negedge clock);
        wren = 1'b0;
        addr = 8'h00;
        din  = 32'h0;
    endtask

    // Combinational status read; touches no DUT state.
    task automatic readStatus(output logic [31:0] v);
        addr = 8'hFE;
        #1;
        v = rdata;
        addr = 8'h00;
    endtask

    // Expected tx waveform for one frame, one bit per clock cycle.
    function automatic logic [63:0] frameWave(input logic [7:0] b);
        logic [63:0] w;
        int slot;
        w = '0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            slot = k / CPB;
            if (slot == 0)
                w[k] = 1'b0;
            else if (slot <= 8)
                w[k] = b[slot-1];
`ifdef UART_PARITY_EN
            else if (slot == 9)
                w[k] = ^b;
`endif
            else
                w[k] = 1'b1;
        end
        return w;
    endfunction

    // Sample tx for one frame, starting at the negedge right after the pop.
    task automatic captureFrame(output logic [63:0] wave, output logic allBusy);
        wave    = '0;
        allBusy = 1'b1;
        for (int k = 0; k < FRAME_CYC; k++) begin
            wave[k] = tx;
            allBusy = allBusy & tx_busy;
            @(negedge clock);
        end
    endtask

    logic [63:0] wave;
    logic        allBusy;
    logic [31:0] status;
    logic        allHigh;
    logic        anyBusy;

    initial begin
        clear = 1'b1;
        wren  = 1'b0;
        addr  = 8'h00;
        din   = 32'h0;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_tx", tx, 1'b1);
        checkOutput("rst_busy", tx_busy, 1'b0);
        checkOutput("rst_count", fifo_count, 4'd0);
        checkOutput("rst_full", fifo_full, 1'b0);
        checkOutput("rst_ovf", overflow, 1'b0);
        addr = 8'hFF; #1;
        checkOutput("rst_rdata_ff", rdata, 32'h0);
        readStatus(status);
        checkOutput("rst_rdata_fe", status, 32'h0);
        clear = 1'b0;
        @(negedge clock);

        // Single byte 0x55: queued at edge N, popped at N+1
        applyStimulus(1'b1, 8'hFF, 32'hDEAD_BE55);
        checkOutput("single_count_n", fifo_count, 4'd1);
        checkOutput("single_tx_n", tx, 1'b1);
        checkOutput("single_busy_n", tx_busy, 1'b0);
        @(negedge clock);
        checkOutput("single_count_n1", fifo_count, 4'd0);
        captureFrame(wave, allBusy);
        checkOutput("single_wave", wave, frameWave(8'h55));
        checkOutput("single_busy_frame", allBusy, 1'b1);
        checkOutput("single_busy_fall", tx_busy, 1'b0);
        checkOutput("single_tx_idle", tx, 1'b1);

        // Address filter: other address, status address, and wren low
        applyStimulus(1'b1, 8'hFE, 32'h12);
        applyStimulus(1'b1, 8'h00, 32'h34);
        applyStimulus(1'b0, 8'hFF, 32'h56);
        allHigh = 1'b1;
        anyBusy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            allHigh = allHigh & tx;
            anyBusy = anyBusy | tx_busy;
            @(negedge clock);
        end
        checkOutput("filter_count", fifo_count, 4'd0);
        checkOutput("filter_tx_high", allHigh, 1'b1);
        checkOutput("filter_busy", anyBusy, 1'b0);
        addr = 8'h00; #1;
        checkOutput("filter_rdata_00", rdata, 32'h0);
        @(negedge clock);

        // Overflow: ten back-to-back stores 0x41..0x4A; 0x4A is dropped
        fork
            begin
                for (int i = 0; i < 10; i++)
                    applyStimulus(1'b1, 8'hFF, 32'(8'h41 + i));
                checkOutput("ovf_count", fifo_count, 4'd8);
                checkOutput("ovf_full", fifo_full, 1'b1);
                checkOutput("ovf_flag", overflow, 1'b1);
                // first frame still on the wire: overflow, busy and full all set
                readStatus(status);
                checkOutput("ovf_status", status, 32'h7);
            end
            begin
                @(posedge clock);
                @(posedge clock);
                @(negedge clock);
                for (int i = 0; i < 9; i++) begin
                    captureFrame(wave, allBusy);
                    checkOutput($sformatf("ovf_wave_%0d", i), wave, frameWave(8'(8'h41 + i)));
                    checkOutput($sformatf("ovf_busy_%0d", i), allBusy, 1'b1);
                    checkOutput($sformatf("ovf_gap_busy_%0d", i), tx_busy, 1'b0);
                    checkOutput($sformatf("ovf_gap_tx_%0d", i), tx, 1'b1);
                    if (i < 8) @(negedge clock);
                end
            end
        join
        checkOutput("ovf_drain_count", fifo_count, 4'd0);
        readStatus(status);
        checkOutput("ovf_drain_status", status, 32'h4);
        @(negedge clock);

        // Reset mid-frame: 0xA5 transmitting, 0x3C queued behind it
        applyStimulus(1'b1, 8'hFF, 32'hA5);
        applyStimulus(1'b1, 8'hFF, 32'h3C);
        checkOutput("mid_push_pop_count", fifo_count, 4'd1);
        repeat (17) @(negedge clock);
        checkOutput("mid_bit3_tx", tx, 1'b0);
        checkOutput("mid_bit3_busy", tx_busy, 1'b1);
        clear = 1'b1;
        @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        checkOutput("mid_rst_tx", tx, 1'b1);
        checkOutput("mid_rst_busy", tx_busy, 1'b0);
        checkOutput("mid_rst_count", fifo_count, 4'd0);
        checkOutput("mid_rst_ovf", overflow, 1'b0);
        allHigh = 1'b1;
        anyBusy = 1'b0;
        for (int k = 0; k < 60; k++) begin
            allHigh = allHigh & tx;
            anyBusy = anyBusy | tx_busy;
            @(negedge clock);
        end
        checkOutput("mid_no_residual_tx", allHigh, 1'b1);
        checkOutput("mid_no_residual_busy", anyBusy, 1'b0);

`ifdef UART_PARITY_EN
        // Parity: 0x07 has odd weight -> parity 1, 0x03 -> parity 0; frames back to back
        applyStimulus(1'b1, 8'hFF, 32'h07);
        applyStimulus(1'b1, 8'hFF, 32'h03);
        captureFrame(wave, allBusy);
        checkOutput("par_wave_07", wave, frameWave(8'h07));
        checkOutput("par_bit_07", wave[9*CPB], 1'b1);
        checkOutput("par_gap_busy", tx_busy, 1'b0);
        @(negedge clock);
        captureFrame(wave, allBusy);
        checkOutput("par_wave_03", wave, frameWave(8'h03));
        checkOutput("par_bit_03", wave[9*CPB], 1'b0);
        checkOutput("par_end_busy", tx_busy, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
